seq_restoring_divider: RTL and testbench

Iterative unsigned N-bit restoring divider that consumes the difference and borrow-out of an N+1-bit ripple-borrow subtraction once per cycle. It sits directly downstream of the team's N-bit subtractor stage in the arithmetic datapath and turns its per-cycle trial subtraction into a quotient/remainder pair over N cycles. It uses a start/busy/done handshake toward the issuing controller.

---
 rtl/seq_restoring_divider.sv | 164 ++++++++++++++++
 tb/tb_seq_restoring_divider.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//
// Iterative N-bit restoring divider. It runs one trial subtraction per cycle
// and needs N cycles per division. A start/busy/done handshake faces the
// issuing controller.
//
// Optional feature macro: DIVIDER_SIGNED_EN
//   Defined: operands are two's complement. Magnitudes are divided unsigned.
//   The quotient truncates toward zero and the remainder takes the sign of the
//   dividend. The sign fix-up is applied on entry to DONE.
//   Undefined: unsigned only.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   start        in   request a division (ignored while busy)
//   dividend     in   N-bit numerator, captured on accepted start
//   divisor      in   N-bit denominator, captured on accepted start
//   busy         out  high while iterating
//   done         out  one-cycle pulse; results valid from this cycle on
//   quotient     out  registered quotient
//   remainder    out  registered remainder
//   div_by_zero  out  set with done when the captured divisor was zero
module seq_restoring_divider #(
  parameter int unsigned N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero
);

  localparam int unsigned CntW = $clog2(N);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e         state_q;
  logic [N-1:0]   d_q;      // captured divisor magnitude
  logic [N-1:0]   q_q;      // dividend shifting out, quotient shifting in
  // Partial remainder. Its top bit is provably 0 after every iteration
  // (R < D always holds), so only the low N bits are stored.
  logic [N-1:0]   r_q;
  logic [CntW-1:0] cnt_q;

`ifdef DIVIDER_SIGNED_EN
  logic q_neg_q;  // operand signs differ
  logic r_neg_q;  // dividend negative
`endif

  // Datapath signals
  logic [N:0]   s;        // shifted value {R, Q msb}
  logic [N-1:0] t;        // low N bits of the trial difference
  logic [N:0]   bw;       // ripple borrow chain
  logic         borrow;
  logic [N-1:0] r_nxt;
  logic [N-1:0] q_nxt;
  logic [N-1:0] fin_q;
  logic [N-1:0] fin_r;
  logic [N-1:0] dvd_mag;
  logic [N-1:0] dvs_mag;

  // Ripple-borrow subtraction of {1'b0, D} from S, borrow-in 0. The top
  // subtrahend bit is 0, so the last stage reduces to a borrow term only.
  always_comb begin
    s     = {r_q, q_q[N-1]};
    t     = '0;
    bw    = '0;
    for (int i = 0; i < N; i++) begin
      t[i]    = s[i] ^ d_q[i] ^ bw[i];
      bw[i+1] = (~s[i] & d_q[i]) | (~(s[i] ^ d_q[i]) & bw[i]);
    end
    borrow = ~s[N] & bw[N];
    // On borrow restore S; S[N] must then be 0 since the old R was below D.
    r_nxt  = borrow ? s[N-1:0] : t;
    q_nxt  = {q_q[N-2:0], ~borrow};
  end

  // Operand magnitudes and final result fix-up.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dvd_mag = dividend[N-1] ? (~dividend + 1'b1) : dividend;
    dvs_mag = divisor[N-1]  ? (~divisor + 1'b1)  : divisor;
    fin_q   = q_neg_q ? (~q_nxt + 1'b1) : q_nxt;
    fin_r   = r_neg_q ? (~r_nxt + 1'b1) : r_nxt;
`else
    dvd_mag = dividend;
    dvs_mag = divisor;
    fin_q   = q_nxt;
    fin_r   = r_nxt;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      d_q         <= '0;
      q_q         <= '0;
      r_q         <= '0;
      cnt_q       <= '0;
`ifdef DIVIDER_SIGNED_EN
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            if (divisor == '0) begin
              // Zero divisor skips iteration and reports straight away.
              state_q     <= StDone;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state_q <= StRun;
              busy    <= 1'b1;
              d_q     <= dvs_mag;
              q_q     <= dvd_mag;
              r_q     <= '0;
              cnt_q   <= '0;
`ifdef DIVIDER_SIGNED_EN
              q_neg_q <= dividend[N-1] ^ divisor[N-1];
              r_neg_q <= dividend[N-1];
`endif
            end
          end else begin
            state_q <= StIdle;
          end
        end
        StRun: begin
          r_q   <= r_nxt;
          q_q   <= q_nxt;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CntW'(N - 1)) begin
            state_q     <= StDone;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= fin_q;
            remainder   <= fin_r;
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
module tb_seq_restoring_divider;

  localparam int unsigned N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_by_zero;

  typedef struct packed {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  seq_restoring_divider #(.N(N)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Reference result from the language's own division operators.
  function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b);
    exp_t m;
    if (b == '0) begin
      m.q   = '1;
      m.r   = a;
      m.dbz = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      int sa, sb_, qq, rr;
      sa  = $signed(a);
      sb_ = $signed(b);
      qq  = sa / sb_;
      rr  = sa % sb_;
      m.q = qq[N-1:0];
      m.r = rr[N-1:0];
`else
      m.q = a / b;
      m.r = a % b;
`endif
      m.dbz = 1'b0;
    end
    return m;
  endfunction

  // Called at a negedge; returns at the negedge of cycle E+1.
  task automatic drive_start(input logic [N-1:0] a, input logic [N-1:0] b);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL reset busy=%b done=%b q=%h r=%h dbz=%b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    drive_start(8'd100, 8'd7);
    for (int k = 1; k <= N; k++) begin
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy E+%0d busy=%b done=%b required busy=1 done=0", k, busy, done);
      end
      @(negedge clk);
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL basic_done E+%0d busy=%b done=%b required busy=0 done=1", N + 1, busy, done);
    end
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL basic_result q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL basic_pulse done=%b required 0", done);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [N-1:0] av[2];
    logic [N-1:0] bv[2];
    av[0] = 8'd255; bv[0] = 8'd1;
    av[1] = 8'd3;   bv[1] = 8'd10;
    for (int j = 0; j < 2; j++) begin
      drive_start(av[j], bv[j]);
      if (j == 1) begin
        checks++;
        if (busy !== 1'b1) begin
          errors++;
          $display("FAIL b2b_busy busy=%b required 1 after start in DONE", busy);
        end
      end
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != N + 1) begin
        errors++;
        $display("FAIL b2b_latency op%0d latency=%0d required %0d", j, lat, N + 1);
      end
      e = sb.pop_front();
      checks++;
      if ({quotient, remainder, div_by_zero} !== e) begin
        errors++;
        $display("FAIL b2b_result op%0d q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
                 j, quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_div_zero();
    drive_start(8'd5, 8'd0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_timing busy=%b done=%b required busy=0 done=1", busy, done);
    end
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL dz_result q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL dz_after busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_ignore_start();
    int lat;
    drive_start(8'd200, 8'd9);
    lat = 1;
    repeat (2) begin
      @(negedge clk);
      lat++;
    end
    start = 1'b1; dividend = 8'd50; divisor = 8'd5;
    @(negedge clk);
    lat++;
    start = 1'b0; dividend = '0; divisor = '0;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    if (lat != N + 1) begin
      errors++;
      $display("FAIL ignore_latency latency=%0d required %0d", lat, N + 1);
    end
    e = sb.pop_front();
    checks++;
    if ({quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL ignore_result q=%h r=%h dbz=%b required q=%h r=%h dbz=%b",
               quotient, remainder, div_by_zero, e.q, e.r, e.dbz);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL ignore_idle busy=%b done=%b required 0 0", busy, done);
    end
  endtask

  task automatic test_rst_abort();
    int lat;
    drive_start(8'd200, 8'd9);
    repeat (3) @(negedge clk);  // now in the 4th RUN cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(sb.pop_back());  // aborted, never completes
    checks++;
    if ({busy, done, quotient, remainder, div_by_zero} !== '0) begin
      errors++;
      $display("FAIL abort_reset busy=%b done=%b q=%h r=%h dbz=%b required all 0",
               busy, done, quotient, remainder, div_by_zero);
    end
    repeat (N + 2) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL abort_idle busy=%b done=%b required 0 0", busy, done);
      end
    end
    drive_start(8'd17, 8'd4);
    lat = 1;
    while (done !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    e = sb.pop_front();
    checks++;
    if (lat != N + 1 || {quotient, remainder, div_by_zero} !== e) begin
      errors++;
      $display("FAIL abort_fresh lat=%0d q=%h r=%h dbz=%b required lat=%0d q=%h r=%h dbz=%b",
               lat, quotient, remainder, div_by_zero, N + 1, e.q, e.r, e.dbz);
    end
    @(negedge clk);
  endtask

  task automatic run_list(input string tag, input logic [N-1:0] av[], input logic [N-1:0] bv[]);
    int lat;
    int want;
    for (int j = 0; j < av.size(); j++) begin
      want = (bv[j] == '0) ? 1 : N + 1;
      drive_start(av[j], bv[j]);
      lat = 1;
      while (done !== 1'b1 && lat < 40) begin
        @(negedge clk);
        lat++;
      end
      e = sb.pop_front();
      checks++;
      if (lat != want || {quotient, remainder, div_by_zero} !== e) begin
        errors++;
        $display("FAIL %s %0d/%0d lat=%0d q=%h r=%h dbz=%b required lat=%0d q=%h r=%h dbz=%b",
                 tag, av[j], bv[j], lat, quotient, remainder, div_by_zero, want, e.q, e.r, e.dbz);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [N-1:0] av[];
    logic [N-1:0] bv[];
    av = new[8];
    bv = new[8];
    for (int j = 0; j < 8; j++) begin
      av[j] = N'($urandom_range(0, 255));
      bv[j] = (j == 5) ? '0 : N'($urandom_range(1, 255));
    end
    av[0] = 8'd255; bv[0] = 8'd255;
    av[1] = 8'd0;   bv[1] = 8'd3;
    run_list("random", av, bv);
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    logic [N-1:0] av[];
    logic [N-1:0] bv[];
    av = new[4];
    bv = new[4];
    av[0] = 8'h9C; bv[0] = 8'd7;    // -100 / 7
    av[1] = 8'h80; bv[1] = 8'hFF;   // -128 / -1
    av[2] = 8'd100; bv[2] = 8'hF9;  // 100 / -7
    av[3] = 8'h9C; bv[3] = 8'hF9;   // -100 / -7
    run_list("signed", av, bv);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_div_zero();
    test_ignore_start();
    test_rst_abort();
    test_random();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
